uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter BAUD, default 115200, line bit rate in bits/s.
REQ-002 Parameter F, default 50000000, clk frequency in Hz.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-005 data  input  8  byte to transmit; sampled once per frame, at frame start.
REQ-006 tx  output  1  serial line, idle/mark level 1.

Function
REQ-007 The block SHALL derive bit period DIV = F/BAUD (integer truncation; 434 clocks at defaults); DIV < 2 SHALL be rejected at elaboration.
REQ-008 A baud tick SHALL pulse for one clk every DIV clocks; the counter restarts at 0 after each tick and on reset.
REQ-009 The FSM SHALL have exactly four states: START, DATA, STOP, IDLE. State changes occur only on a baud tick.
REQ-010 IDLE: tx=1 for one bit period, then -> START (free-running; no valid/handshake input).
REQ-011 On the IDLE->START transition the block SHALL latch data into an 8-bit shift register; later changes to data affect only the next frame.
REQ-012 START: tx=0 for one bit period, then -> DATA with bit index 0.
REQ-013 DATA: tx = latched bit[index], LSB first, one bit period each; after index 7 -> STOP.
REQ-014 STOP: tx=1 for one bit period, then -> IDLE.
REQ-015 Frame format 8N1 plus one idle bit; frame length SHALL be 11*DIV clocks (4774 at defaults), repeating back-to-back indefinitely.
REQ-016 tx SHALL be driven from a register (glitch-free, no combinational path from data to tx).
REQ-017 The bit index SHALL be 3 bits, cleared on entry to START; no wrap-around beyond 7 is reachable.

Reset
REQ-018 While rst=0: state=IDLE, tx=1, baud counter=0, bit index=0, shift register=0, asynchronously.
REQ-019 After rst rises, the first frame's start bit SHALL begin exactly DIV clocks later (one full IDLE bit).
REQ-020 Reset asserted mid-frame SHALL abort the frame immediately, forcing tx=1; no partial-frame resumption.

Structure
REQ-021 A shared package SHALL hold the state encoding constants START=2'b00, DATA=2'b01, STOP=2'b10, IDLE=2'b11 and the DIV computation function.
REQ-022 One sub-module, uart_tx_baud_gen (params BAUD, F; ports clk, rst, tick), SHALL implement REQ-007/008; the FSM and shift register live in uart_tx.

Verification
REQ-023 Hold rst=0 several clocks -> tx=1 throughout; release -> tx stays 1 for 434 clocks, then falls to 0.
REQ-024 data=8'hD3 at defaults -> tx sequence per 434-clock bit: 0 (start), 1,1,0,0,1,0,1,1 (LSB first), 1 (stop), 1 (idle), then the next start bit.
REQ-025 Change data to 8'h2C mid-frame -> current frame still carries 0xD3; next frame carries 0,0,1,1,0,1,0,0 data bits.
REQ-026 Assert rst during DATA bit 4 -> tx=1 asynchronously (before next clk edge); after release, full 434-clock idle precedes a fresh start bit.
REQ-027 Parameter override BAUD=F/4 (DIV=4) -> each bit exactly 4 clocks, frame exactly 44 clocks, back-to-back.
REQ-028 Constant data=8'hFF or 8'h00 over 3 frames -> only start bits (0) / only stop+idle bits (1) differ as specified; frame period constant at 11*DIV.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the uart_tx transmitter: FSM state encoding,
// datapath widths and the bit-period helper.
package uart_tx_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned IDX_W  = 3;

    typedef enum logic [1:0] {
        START = 2'b00,
        DATA  = 2'b01,
        STOP  = 2'b10,
        IDLE  = 2'b11
    } state_t;

    // Clocks per line bit, truncated.
    function automatic int unsigned calc_div(input int unsigned f, input int unsigned baud);
        return f / baud;
    endfunction

endpackage

// File: rtl/uart_tx_baud_gen.sv
// Baud tick generator: one-clock tick every DIV = F/BAUD clocks.
// Ports: clk (system clock), rst (async active-low reset), tick (bit-period pulse).
module uart_tx_baud_gen #(
    parameter int unsigned BAUD = 115200,
    parameter int unsigned F    = 50000000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    import uart_tx_pkg::*;

    localparam int unsigned DIV  = calc_div(F, BAUD);
    localparam int unsigned CW   = (DIV < 2) ? 1 : $clog2(DIV);
    localparam int unsigned LAST = (DIV < 2) ? 0 : DIV - 1;

    if (DIV < 2) begin : g_bad_div
        $error("uart_tx_baud_gen: F/BAUD must be at least 2");
    end

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    // Counter wraps to 0 after reaching LAST.
    always_comb begin
        cnt_next = cnt + CW'(1);
        if (cnt == CW'(LAST)) begin
            cnt_next = '0;
        end
    end

    // tick is high exactly while the counter holds LAST, but comes from a flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= cnt_next;
            tick <= (cnt_next == CW'(LAST));
        end
    end

endmodule

// File: rtl/uart_tx.sv
// Free-running 8N1 UART transmitter: idle bit, start bit, 8 data bits LSB
// first, stop bit, repeated back-to-back. data is latched at each frame start.
// Ports: clk (system clock), rst (async active-low reset),
//        data (byte for the next frame), tx (registered serial line, idle 1).
module uart_tx #(
    parameter int unsigned BAUD = 115200,
    parameter int unsigned F    = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    output logic       tx
);
    import uart_tx_pkg::*;

    logic              tick;
    state_t            state;
    logic [DATA_W-1:0] shreg;
    logic [IDX_W-1:0]  idx;

    uart_tx_baud_gen #(
        .BAUD (BAUD),
        .F    (F)
    ) u_baud_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Frame sequencer; tx is loaded with the level of the state being entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            tx    <= 1'b1;
            shreg <= '0;
            idx   <= '0;
        end else if (tick) begin
            case (state)
                IDLE: begin
                    state <= START;
                    shreg <= data;
                    idx   <= '0;
                    tx    <= 1'b0;
                end
                START: begin
                    state <= DATA;
                    idx   <= '0;
                    tx    <= shreg[0];
                end
                DATA: begin
                    if (idx == IDX_W'(7)) begin
                        state <= STOP;
                        tx    <= 1'b1;
                    end else begin
                        idx <= idx + IDX_W'(1);
                        tx  <= shreg[idx + IDX_W'(1)];
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: default-rate instance (DIV=434) and a
// DIV=4 instance, both compared every clock against a slot-based frame model.
module tb_uart_tx;

    localparam int unsigned F_HZ   = 50000000;
    localparam int unsigned BAUD_A = 115200;
    localparam int unsigned BAUD_B = F_HZ / 4;
    localparam int          DIV_A  = 434;
    localparam int          DIV_B  = 4;

    logic       clk = 1'b0;
    logic       rst_a;
    logic       rst_b;
    logic [7:0] data_a;
    logic [7:0] data_b;
    logic       tx_a;
    logic       tx_b;

    always #5 clk = ~clk;

    uart_tx #(.BAUD(BAUD_A), .F(F_HZ)) u_dut_a (
        .clk  (clk),
        .rst  (rst_a),
        .data (data_a),
        .tx   (tx_a)
    );

    uart_tx #(.BAUD(BAUD_B), .F(F_HZ)) u_dut_b (
        .clk  (clk),
        .rst  (rst_b),
        .data (data_b),
        .tx   (tx_b)
    );

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    logic [7:0] frame_bytes [0:7];

    // Expected line level n clocks after reset release, given the frame's byte.
    // Frame = 11 slots of div clocks: idle, start, d0..d7, stop.
    function automatic logic model_tx(input int div, input int n, input logic [7:0] b);
        int p;
        int s;
        p = n % (11 * div);
        s = p / div;
        if (s == 1) return 1'b0;
        if (s >= 2 && s <= 9) return b[s - 2];
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp, input int n);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s n=%0d: tx=%b expected %b", tag, n, obs, exp);
        end
    endtask

    task automatic set_data(input bit sel, input logic [7:0] v);
        if (sel) data_b = v;
        else     data_a = v;
    endtask

    // Runs nedges clocks after a release, changing data mid-frame to the next
    // frame's byte and checking tx after every edge.
    task automatic run(input bit sel, input int div, input int nedges, input string tag);
        int len;
        int f;
        logic exp;
        len = 11 * div;
        for (int n = 1; n <= nedges; n++) begin
            if ((n % len) == 3 * div) begin
                f = n / len;
                if (f + 1 < 8) set_data(sel, frame_bytes[f + 1]);
            end
            @(posedge clk);
            @(negedge clk);
            f = n / len;
            if (f > 7) f = 7;
            exp = model_tx(div, n, frame_bytes[f]);
            chk(tag, sel ? tx_b : tx_a, exp, n);
        end
    endtask

    initial begin
        rst_a  = 1'b1;
        rst_b  = 1'b1;
        data_a = 8'hD3;
        data_b = 8'h00;
        #2;
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Held in reset: line idles high.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("reset_hold_a", tx_a, 1'b1, i);
            chk("reset_hold_b", tx_b, 1'b1, i);
        end

        // Default rate: 0xD3 frame, data switched to 0x2C mid-frame.
        frame_bytes[0] = 8'hD3;
        for (int i = 1; i < 8; i++) frame_bytes[i] = 8'h2C;
        set_data(1'b0, frame_bytes[0]);
        rst_a = 1'b1;
        run(1'b0, DIV_A, 3 * 11 * DIV_A + DIV_A + 1, "frames_d3_2c");

        // Re-reset, then abort during data bit 4 (0x2C bit 4 is 0).
        @(negedge clk);
        rst_a = 1'b0;
        #1;
        chk("rereset_async", tx_a, 1'b1, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rereset_hold", tx_a, 1'b1, i);
        end
        frame_bytes[0] = 8'h2C;
        set_data(1'b0, frame_bytes[0]);
        rst_a = 1'b1;
        run(1'b0, DIV_A, 6 * DIV_A + DIV_A / 2, "pre_abort");
        rst_a = 1'b0;
        #1;
        chk("abort_async", tx_a, 1'b1, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_hold", tx_a, 1'b1, i);
        end
        for (int i = 0; i < 8; i++) frame_bytes[i] = 8'($urandom);
        set_data(1'b0, frame_bytes[0]);
        rst_a = 1'b1;
        run(1'b0, DIV_A, 12 * DIV_A + 2, "post_abort");

        // DIV=4 instance: random bytes, back-to-back 44-clock frames.
        for (int i = 0; i < 8; i++) frame_bytes[i] = 8'($urandom);
        set_data(1'b1, frame_bytes[0]);
        @(negedge clk);
        rst_b = 1'b1;
        run(1'b1, DIV_B, 8 * 11 * DIV_B, "div4_random");

        // Constant 0xFF, then 0x00, over three frames each.
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            rst_b = 1'b0;
            #1;
            chk("div4_reset", tx_b, 1'b1, k);
            for (int i = 0; i < 8; i++) frame_bytes[i] = (k == 0) ? 8'hFF : 8'h00;
            set_data(1'b1, frame_bytes[0]);
            @(negedge clk);
            rst_b = 1'b1;
            run(1'b1, DIV_B, 3 * 11 * DIV_B + DIV_B + 1, (k == 0) ? "div4_ones" : "div4_zeros");
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
